multicycle_controller: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 30 +++
 rtl/multicycle_controller.sv | 129 ++++++++++++
 tb/tb_multicycle_controller.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller and the datapath muxes it steers.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluDirect = 2'b10;

  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;
  localparam logic [1:0] OpUndef  = 2'b11;

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: steps each ARMv7 instruction through fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port, gating architectural writes by the condition check.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
(
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic [1:0] i_Op,
  input  logic       i_Immediate_Enable,
  input  logic       i_Set_Condition,
  input  logic       i_Cond_Ex,
  input  logic       i_Mem_Ready,
  output logic       o_PC_Write,
  output logic       o_IR_Write,
  output logic       o_Address_Src,
  output logic       o_ALU_Src_A,
  output logic [1:0] o_ALU_Src_B,
  output logic       o_ALU_Op,
  output logic [1:0] o_Result_Src,
  output logic       o_Port3_Write_Enable,
  output logic       o_Memory_Write_Enable,
  output logic [1:0] o_Immediate_Src,
  output logic       o_Instr_Done,
  output logic [3:0] o_State
);

  state_e state_q, state_d, cur_state;

  // While reset is held the outputs decode as FETCH so nothing downstream sees a stale state.
  assign cur_state       = i_Reset_n ? state_q : StFetch;
  assign o_State         = cur_state;
  assign o_Immediate_Src = i_Op;

  always_comb begin
    state_d               = StFetch;
    o_PC_Write            = 1'b0;
    o_IR_Write            = 1'b0;
    o_Address_Src         = 1'b0;
    o_ALU_Src_A           = 1'b0;
    o_ALU_Src_B           = SrcBReg;
    o_ALU_Op              = 1'b0;
    o_Result_Src          = ResAluOut;
    o_Port3_Write_Enable  = 1'b0;
    o_Memory_Write_Enable = 1'b0;
    o_Instr_Done          = 1'b0;
    case (cur_state)
      StFetch: begin
        o_ALU_Src_A  = 1'b1;
        o_ALU_Src_B  = SrcBFour;
        o_Result_Src = ResAluDirect;
        o_IR_Write   = i_Mem_Ready;
        o_PC_Write   = i_Mem_Ready;
        state_d      = i_Mem_Ready ? StDecode : StFetch;
      end
      StDecode: begin
        o_ALU_Src_A  = 1'b1;
        o_ALU_Src_B  = SrcBFour;
        o_Result_Src = ResAluDirect;
        unique case (i_Op)
          OpMem:    state_d = StMemAdr;
          OpDp:     state_d = i_Immediate_Enable ? StExecI : StExecR;
          OpBranch: state_d = StBranch;
          OpUndef: begin
            state_d      = StFetch;
            o_Instr_Done = 1'b1;
          end
          default:  state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        o_ALU_Src_B = SrcBImm;
        state_d     = i_Set_Condition ? StMemRd : StMemWr;
      end
      StMemRd: begin
        o_Address_Src = 1'b1;
        state_d       = i_Mem_Ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        o_Result_Src         = ResMemData;
        o_Port3_Write_Enable = i_Cond_Ex;
        o_Instr_Done         = 1'b1;
      end
      StMemWr: begin
        // A failed condition skips the access entirely rather than waiting on memory.
        o_Address_Src         = 1'b1;
        o_Memory_Write_Enable = i_Cond_Ex;
        o_Instr_Done          = ~i_Cond_Ex | i_Mem_Ready;
        state_d               = o_Instr_Done ? StFetch : StMemWr;
      end
      StExecR: begin
        o_ALU_Op = 1'b1;
        state_d  = StAluWb;
      end
      StExecI: begin
        o_ALU_Src_B = SrcBImm;
        o_ALU_Op    = 1'b1;
        state_d     = StAluWb;
      end
      StAluWb: begin
        o_Result_Src         = ResAluOut;
        o_Port3_Write_Enable = i_Cond_Ex;
        o_Instr_Done         = 1'b1;
      end
      StBranch: begin
        o_ALU_Src_B  = SrcBImm;
        o_Result_Src = ResAluDirect;
        o_PC_Write   = i_Cond_Ex;
        o_Instr_Done = 1'b1;
      end
      default: state_d = StFetch;
    endcase
    if (!i_Reset_n) begin
      o_PC_Write            = 1'b0;
      o_IR_Write            = 1'b0;
      o_Port3_Write_Enable  = 1'b0;
      o_Memory_Write_Enable = 1'b0;
      o_Instr_Done          = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: instructions are expanded into expected per-cycle phases and every cycle is
// compared against the output table; directed cases pin cycle counts and strobe positions.
module tb_multicycle_controller;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, imm, setc, cond, ready;
  logic [1:0] op;
  logic       pc_write, ir_write, address_src, alu_src_a, alu_op;
  logic [1:0] alu_src_b, result_src, immediate_src;
  logic       port3_we, mem_we, instr_done;
  logic [3:0] state;

  multicycle_controller dut (
    .i_Clock              (clk),
    .i_Reset_n            (rst_n),
    .i_Op                 (op),
    .i_Immediate_Enable   (imm),
    .i_Set_Condition      (setc),
    .i_Cond_Ex            (cond),
    .i_Mem_Ready          (ready),
    .o_PC_Write           (pc_write),
    .o_IR_Write           (ir_write),
    .o_Address_Src        (address_src),
    .o_ALU_Src_A          (alu_src_a),
    .o_ALU_Src_B          (alu_src_b),
    .o_ALU_Op             (alu_op),
    .o_Result_Src         (result_src),
    .o_Port3_Write_Enable (port3_we),
    .o_Memory_Write_Enable(mem_we),
    .o_Immediate_Src      (immediate_src),
    .o_Instr_Done         (instr_done),
    .o_State              (state)
  );

  typedef struct {
    logic       rst;
    state_e     st;
    logic [1:0] op;
    logic       imm;
    logic       setc;
    logic       cond;
    logic       ready;
  } cyc_t;

  cyc_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          ncyc;
  logic [31:0] done_mask, p3we_mask, pcw_mask, irw_mask, mwe_mask;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic void push(state_e st, logic ready_v, logic cond_v, logic [1:0] op_v,
                               logic imm_v, logic setc_v, logic rst_v = 1'b1);
    q.push_back('{rst: rst_v, st: st, op: op_v, imm: imm_v, setc: setc_v, cond: cond_v,
                  ready: ready_v});
  endfunction

  // Inputs that the phase does not sample are randomized to prove they are ignored.
  function automatic void build_instr(logic [1:0] o, logic i, logic l, logic c,
                                      int fw, int rw, int ww);
    for (int k = 0; k < fw; k++) push(StFetch, 1'b0, rb(), rop(), rb(), rb());
    push(StFetch, 1'b1, rb(), rop(), rb(), rb());
    push(StDecode, rb(), rb(), o, i, l);
    case (o)
      2'b00: begin
        push(i ? StExecI : StExecR, rb(), rb(), rop(), rb(), rb());
        push(StAluWb, rb(), c, rop(), rb(), rb());
      end
      2'b01: begin
        push(StMemAdr, rb(), rb(), o, i, l);
        if (l) begin
          for (int k = 0; k < rw; k++) push(StMemRd, 1'b0, rb(), rop(), rb(), rb());
          push(StMemRd, 1'b1, rb(), rop(), rb(), rb());
          push(StMemWb, rb(), c, rop(), rb(), rb());
        end else if (!c) begin
          push(StMemWr, rb(), 1'b0, rop(), rb(), rb());
        end else begin
          for (int k = 0; k < ww; k++) push(StMemWr, 1'b0, 1'b1, rop(), rb(), rb());
          push(StMemWr, 1'b1, 1'b1, rop(), rb(), rb());
        end
      end
      2'b10: push(StBranch, rb(), c, rop(), rb(), rb());
      default: ;
    endcase
  endfunction

  // Output table: {pcw, irw, addr, srcA, srcB, aluop, result, p3we, mwe, done, immsrc, state}.
  function automatic logic [18:0] expect_out(cyc_t c);
    logic pcw = 0, irw = 0, addr = 0, srca = 0, aluop = 0, p3we = 0, mwe = 0, done = 0;
    logic [1:0] srcb = 2'b00, res = 2'b00;
    state_e st;
    st = c.rst ? c.st : StFetch;
    case (st)
      StFetch: begin
        srca = 1; srcb = 2'b10; res = 2'b10; pcw = c.ready; irw = c.ready;
      end
      StDecode: begin
        srca = 1; srcb = 2'b10; res = 2'b10; done = (c.op == 2'b11);
      end
      StMemAdr: srcb = 2'b01;
      StMemRd:  addr = 1;
      StMemWb: begin
        res = 2'b01; p3we = c.cond; done = 1;
      end
      StMemWr: begin
        addr = 1; mwe = c.cond; done = !c.cond || c.ready;
      end
      StExecR: aluop = 1;
      StExecI: begin
        srcb = 2'b01; aluop = 1;
      end
      StAluWb: begin
        p3we = c.cond; done = 1;
      end
      StBranch: begin
        srcb = 2'b01; res = 2'b10; pcw = c.cond; done = 1;
      end
      default: ;
    endcase
    if (!c.rst) {pcw, irw, p3we, mwe, done} = 5'b0;
    return {pcw, irw, addr, srca, srcb, aluop, res, p3we, mwe, done, c.op, 4'(st)};
  endfunction

  task automatic run_queue();
    ncyc      = 0;
    done_mask = '0;
    p3we_mask = '0;
    pcw_mask  = '0;
    irw_mask  = '0;
    mwe_mask  = '0;
    while (q.size() > 0) begin
      cyc_t c;
      logic [18:0] e, a;
      c     = q.pop_front();
      rst_n = c.rst;
      op    = c.op;
      imm   = c.imm;
      setc  = c.setc;
      cond  = c.cond;
      ready = c.ready;
      #1;
      e = expect_out(c);
      a = {pc_write, ir_write, address_src, alu_src_a, alu_src_b, alu_op, result_src, port3_we,
           mem_we, instr_done, immediate_src, state};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_outputs phase=%s rst=%b got %h exp %h", c.st.name(), c.rst, a, e);
      end
      if (ncyc < 32) begin
        done_mask[ncyc] = instr_done;
        p3we_mask[ncyc] = port3_we;
        pcw_mask[ncyc]  = pc_write;
        irw_mask[ncyc]  = ir_write;
        mwe_mask[ncyc]  = mem_we;
      end
      ncyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; op = 2'b00; imm = 1'b0; setc = 1'b0; cond = 1'b0; ready = 1'b0;
    @(posedge clk);
    #1;
    push(StFetch, 1'b1, rb(), rop(), rb(), rb(), 1'b0);
    push(StFetch, 1'b1, rb(), rop(), rb(), rb(), 1'b0);
    run_queue();

    build_instr(2'b00, 1'b0, rb(), 1'b1, 0, 0, 0);
    run_queue();
    check("add_done", done_mask, 32'b1000);
    check("add_p3we", p3we_mask, 32'b1000);

    build_instr(2'b01, rb(), 1'b1, 1'b1, 0, 2, 0);
    run_queue();
    check("ldr_done", done_mask, 32'b1000000);
    check("ldr_p3we", p3we_mask, 32'b1000000);

    build_instr(2'b01, rb(), 1'b0, 1'b0, 0, 0, 0);
    run_queue();
    check("str_nc_done", done_mask, 32'b1000);
    check("str_nc_mwe", mwe_mask, 32'b0);

    build_instr(2'b10, rb(), rb(), 1'b1, 0, 0, 0);
    run_queue();
    check("b_taken_done", done_mask, 32'b100);
    check("b_taken_pcw", pcw_mask, 32'b101);

    build_instr(2'b10, rb(), rb(), 1'b0, 0, 0, 0);
    run_queue();
    check("b_not_taken_done", done_mask, 32'b100);
    check("b_not_taken_pcw", pcw_mask, 32'b001);

    build_instr(2'b11, rb(), rb(), rb(), 3, 0, 0);
    run_queue();
    check("undef_irw", irw_mask, 32'b01000);
    check("undef_pcw", pcw_mask, 32'b01000);
    check("undef_done", done_mask, 32'b10000);

    // Store interrupted by reset while the strobe is up and memory is stalled.
    push(StFetch, 1'b1, rb(), rop(), rb(), rb());
    push(StDecode, rb(), rb(), 2'b01, rb(), 1'b0);
    push(StMemAdr, rb(), rb(), 2'b01, rb(), 1'b0);
    push(StMemWr, 1'b0, 1'b1, rop(), rb(), rb());
    push(StMemWr, 1'b1, 1'b1, rop(), rb(), rb(), 1'b0);
    push(StFetch, 1'b0, rb(), rop(), rb(), rb());
    run_queue();
    check("rst_mwe", mwe_mask, 32'b001000);
    check("rst_done", done_mask, 32'b0);
    check("rst_irw", irw_mask, 32'b000001);

    repeat (300) begin
      logic [1:0] o;
      logic       i, l, c;
      int         fw, rw, ww, len;
      o  = rop(); i = rb(); l = rb(); c = rb();
      fw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      ww = $urandom_range(0, 3);
      case (o)
        2'b00:   len = 4;
        2'b01:   len = l ? 5 + rw : (c ? 4 + ww : 4);
        2'b10:   len = 3;
        default: len = 2;
      endcase
      len += fw;
      build_instr(o, i, l, c, fw, rw, ww);
      run_queue();
      check("rand_done_position", done_mask, 32'(1) << (len - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
